// File: rtl/serial_tx_if.sv
// Core-side bus and serial line for serial_tx: qualifier, direction, word address,
// shared tri-state operand bus, and the serial output.
interface serial_tx_if;
   logic        enable;
   logic        rw;
   logic [31:0] addr;
   wire  [31:0] data;
   logic        txd;

   modport master (
      output enable,
      output rw,
      output addr,
      inout  data,
      input  txd
   );

   modport slave (
      input  enable,
      input  rw,
      input  addr,
      inout  data,
      output txd
   );
endinterface

// File: rtl/serial_tx.sv
// Bus-mapped async serial transmitter: byte FIFO at BASE, STATUS at BASE+1,
// 8N1 framing at CLKDIV clocks per bit with back-to-back frames.
//
// state | meaning
// IDLE  | line high, waiting for a byte in the FIFO
// START | start bit (txd=0) for CLKDIV cycles
// DATA  | 8 data bits LSB first, CLKDIV cycles each
// STOP  | stop bit (txd=1) for CLKDIV cycles, then next byte or IDLE
module serial_tx #(
   parameter logic [31:0] BASE   = 32'h0000_0020,
   parameter int unsigned CLKDIV = 16,
   parameter int unsigned DEPTH  = 8
) (
   input logic        clk,
   input logic        reset_n,
   serial_tx_if.slave bus
);
   localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0] ADDR_TX  = BASE;
   localparam logic [31:0] ADDR_ST  = BASE + 32'd1;
   localparam logic [15:0] BIT_TC   = 16'(CLKDIV - 1);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t        state_q;
   logic [15:0]   bit_cnt_q;
   logic [2:0]    bit_idx_q;
   logic [7:0]    shreg_q;
   logic          txd_q;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;
   logic [AW:0]   count_d;
   logic          ovf_q;
   logic          ovf_d;

   logic          empty;
   logic          full;
   logic          bit_tc;
   logic          pop;
   logic          push;
   logic          wr_tx;
   logic          wr_st;
   logic          rd_sel;
   logic [31:0]   status;

   assign empty  = (count_q == '0);
   assign full   = (count_q == FULL_CNT);
   assign bit_tc = (bit_cnt_q == BIT_TC);
   assign pop    = !empty && ((state_q == IDLE) || ((state_q == STOP) && bit_tc));
   assign wr_tx  = bus.enable && bus.rw && (bus.addr == ADDR_TX);
   assign wr_st  = bus.enable && bus.rw && (bus.addr == ADDR_ST);
   // A pop on the same edge frees a slot, so a write to a full FIFO still lands.
   assign push   = wr_tx && (!full || pop);

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + (AW+1)'(1);
      end else if (pop && !push) begin
         count_d = count_q - (AW+1)'(1);
      end
      ovf_d = ovf_q;
      if (wr_tx && !push) begin
         ovf_d = 1'b1;
      end else if (wr_st && bus.data[3]) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= bus.data[7:0];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         bit_idx_q <= '0;
         shreg_q   <= '0;
         txd_q     <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (pop) begin
                  shreg_q   <= mem_q[rd_ptr_q];
                  bit_cnt_q <= '0;
                  txd_q     <= 1'b0;
                  state_q   <= START;
               end
            end
            START: begin
               if (bit_tc) begin
                  bit_cnt_q <= '0;
                  bit_idx_q <= '0;
                  txd_q     <= shreg_q[0];
                  state_q   <= DATA;
               end else begin
                  bit_cnt_q <= bit_cnt_q + 16'd1;
               end
            end
            DATA: begin
               if (bit_tc) begin
                  bit_cnt_q <= '0;
                  if (bit_idx_q == 3'd7) begin
                     txd_q   <= 1'b1;
                     state_q <= STOP;
                  end else begin
                     bit_idx_q <= bit_idx_q + 3'd1;
                     txd_q     <= shreg_q[bit_idx_q + 3'd1];
                  end
               end else begin
                  bit_cnt_q <= bit_cnt_q + 16'd1;
               end
            end
            STOP: begin
               if (bit_tc) begin
                  bit_cnt_q <= '0;
                  if (pop) begin
                     shreg_q <= mem_q[rd_ptr_q];
                     txd_q   <= 1'b0;
                     state_q <= START;
                  end else begin
                     state_q <= IDLE;
                  end
               end else begin
                  bit_cnt_q <= bit_cnt_q + 16'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign status = {21'd0, 7'(count_q), ovf_q, (state_q != IDLE), empty, full};
   // Bus is released during reset so nothing contends while the core comes up.
   assign rd_sel = reset_n && bus.enable && !bus.rw &&
                   ((bus.addr == ADDR_TX) || (bus.addr == ADDR_ST));

   assign bus.data = rd_sel ? status : 32'bz;
   assign bus.txd  = txd_q;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx (CLKDIV=4, DEPTH=8): waveform, STATUS, overflow,
// tri-state release and reset-abort checks against hand-computed values.
module tb_serial_tx;
   localparam logic [31:0] BASE   = 32'h0000_0020;
   localparam int          CLKDIV = 4;
   localparam int          DEPTH  = 8;

   logic        clk     = 1'b0;
   logic        reset_n = 1'b0;
   logic        drv_en  = 1'b0;
   logic [31:0] drv_val = '0;

   serial_tx_if bus();

   assign bus.data = drv_en ? drv_val : 32'bz;

   serial_tx #(
      .BASE  (BASE),
      .CLKDIV(CLKDIV),
      .DEPTH (DEPTH)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", tag, got, exp);
      end
   endtask

   // Independent line receiver: samples mid-bit, queues decoded bytes.
   logic       rx_act  = 1'b0;
   int         rx_t    = 0;
   logic [7:0] rx_sh   = '0;
   logic [7:0] rx_q[$];
   int         rx_ferr = 0;

   always @(negedge clk) begin
      if (!reset_n) begin
         rx_act = 1'b0;
      end else if (!rx_act) begin
         if (bus.txd == 1'b0) begin
            rx_act = 1'b1;
            rx_t   = 0;
         end
      end else begin
         rx_t++;
         if ((rx_t % CLKDIV == CLKDIV/2) && rx_t >= CLKDIV + CLKDIV/2 && rx_t <= 8*CLKDIV + CLKDIV/2)
            rx_sh = {bus.txd, rx_sh[7:1]};
         if (rx_t == 9*CLKDIV + CLKDIV/2) begin
            if (bus.txd !== 1'b1) rx_ferr++;
            rx_q.push_back(rx_sh);
         end
         if (rx_t == 10*CLKDIV - 1) rx_act = 1'b0;
      end
   end

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      bus.enable = 1'b1;
      bus.rw     = 1'b1;
      bus.addr   = a;
      drv_val    = d;
      drv_en     = 1'b1;
      @(posedge clk);
      #1;
      bus.enable = 1'b0;
      bus.rw     = 1'b0;
      drv_en     = 1'b0;
   endtask

   task automatic read_status(input logic [31:0] a, output logic [31:0] v);
      bus.enable = 1'b1;
      bus.rw     = 1'b0;
      bus.addr   = a;
      #1;
      v = bus.data;
      bus.enable = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_frame(input logic [7:0] b, input string tag);
      logic [9:0]  bits;
      logic [3:0]  smp;
      logic        busy_all;
      logic [31:0] st;
      bits     = {1'b1, b, 1'b0};
      busy_all = 1'b1;
      smp      = '0;
      for (int k = 0; k < 10; k++) begin
         for (int c = 0; c < CLKDIV; c++) begin
            @(negedge clk);
            smp[c] = bus.txd;
            read_status(BASE + 32'd1, st);
            busy_all = busy_all & st[2];
         end
         chk($sformatf("%s_bit%0d", tag, k), {28'd0, smp}, bits[k] ? 32'hF : 32'h0);
      end
      chk({tag, "_busy"}, {31'd0, busy_all}, 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] st;
      logic        hi_all;
      int          rx_base;
      int          ferr_base;
      logic [7:0]  exp_b;

      bus.enable = 1'b0;
      bus.rw     = 1'b0;
      bus.addr   = '0;

      // Reset held: line high, bus released even with a qualified read.
      #12;
      bus.enable = 1'b1;
      bus.addr   = BASE + 32'd1;
      #1;
      chk("rst_txd", {31'd0, bus.txd}, 32'd1);
      chk("rst_data_z", {31'd0, (bus.data === 32'bz)}, 32'd1);
      bus.enable = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      tick(2);
      read_status(BASE + 32'd1, st);
      chk("post_rst_status", st, 32'h2);

      // Single frame 0x55; upper data bits must be ignored.
      tick(1);
      bus_write(BASE, 32'hFFFF_FF55);
      @(negedge clk);
      chk("t1_idle_before", {31'd0, bus.txd}, 32'd1);
      check_frame(8'h55, "t1");
      @(negedge clk);
      chk("t1_txd_after", {31'd0, bus.txd}, 32'd1);
      read_status(BASE + 32'd1, st);
      chk("t1_done", st, 32'h2);

      // Back-to-back frames with no idle gap.
      tick(1);
      bus_write(BASE, 32'h0000_00A5);
      bus_write(BASE, 32'h0000_003C);
      check_frame(8'hA5, "t2a");
      check_frame(8'h3C, "t2b");
      @(negedge clk);
      read_status(BASE + 32'd1, st);
      chk("t2_done", st, 32'h2);

      // Overflow: 10 writes while busy, first byte already popped.
      tick(1);
      rx_base   = rx_q.size();
      ferr_base = rx_ferr;
      for (int i = 0; i < 10; i++) bus_write(BASE, 32'h10 + 32'(i));
      read_status(BASE + 32'd1, st);
      chk("t3_full", st, 32'h8D);
      bus_write(BASE + 32'd1, 32'h8);
      read_status(BASE + 32'd1, st);
      chk("t3_ovf_clr", st, 32'h85);
      // Land a write on the edge where STOP of the first frame pops.
      tick(30);
      bus_write(BASE, 32'h2A);
      read_status(BASE + 32'd1, st);
      chk("t3_push_on_pop", st, 32'h85);
      tick(380);
      chk("t3_rx_count", 32'(rx_q.size() - rx_base), 32'd10);
      for (int i = 0; i < 10; i++) begin
         exp_b = (i < 9) ? 8'(8'h10 + i) : 8'h2A;
         if (rx_base + i < rx_q.size())
            chk($sformatf("t3_rx%0d", i), {24'd0, rx_q[rx_base + i]}, {24'd0, exp_b});
      end
      chk("t3_frame_err", 32'(rx_ferr - ferr_base), 32'd0);
      read_status(BASE + 32'd1, st);
      chk("t3_done", st, 32'h2);

      // Tri-state release and occupancy read-back.
      bus.enable = 1'b0;
      bus.rw     = 1'b0;
      bus.addr   = BASE + 32'd1;
      #1;
      chk("t4_en0_z", {31'd0, (bus.data === 32'bz)}, 32'd1);
      bus.enable = 1'b1;
      bus.addr   = BASE + 32'd2;
      #1;
      chk("t4_addr2_z", {31'd0, (bus.data === 32'bz)}, 32'd1);
      bus.enable = 1'b0;
      tick(1);
      bus_write(BASE, 32'h35);
      bus_write(BASE, 32'h01);
      bus_write(BASE, 32'h02);
      bus_write(BASE, 32'h03);
      read_status(BASE + 32'd1, st);
      chk("t4_cnt3", st, 32'h34);
      read_status(BASE, st);
      chk("t4_txdata_rd", st, 32'h34);

      // Reset during DATA bit 3 of 0x35 (bit3 = 0, so the line is low).
      tick(15);
      chk("t5_bit3_low", {31'd0, bus.txd}, 32'd0);
      #2;
      reset_n = 1'b0;
      #1;
      chk("t5_async_txd", {31'd0, bus.txd}, 32'd1);
      bus.enable = 1'b1;
      bus.addr   = BASE + 32'd1;
      #1;
      chk("t5_rst_z", {31'd0, (bus.data === 32'bz)}, 32'd1);
      bus.enable = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      rx_base = rx_q.size();
      tick(2);
      read_status(BASE + 32'd1, st);
      chk("t5_status", st, 32'h2);
      hi_all = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         hi_all = hi_all & bus.txd;
      end
      chk("t5_txd_idle", {31'd0, hi_all}, 32'd1);
      chk("t5_no_rx", 32'(rx_q.size() - rx_base), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 SHALL have parameter BASE, default 32'h0000_0020, word address of the TXDATA register; STATUS sits at BASE+1.
REQ-002 SHALL have parameter CLKDIV, default 16, clock cycles per serial bit; legal range 2..65535.
REQ-003 SHALL have parameter DEPTH, default 8, FIFO entries; power of two, 2..64.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  bus-access qualifier; when low, all bus reads and writes are ignored.
REQ-007 rw  input  1  1 = core writes on data, 0 = core reads from data.
REQ-008 addr  input  32  word address from the core.
REQ-009 data  inout  32  shared operand data bus.
REQ-010 txd  output  1  serial line; idle high.

Function
REQ-011 Writes SHALL be captured on the rising clk edge when enable=1, rw=1 and addr matches a register address.
REQ-012 A write to TXDATA (addr==BASE) SHALL push data[7:0] into the FIFO; data[31:8] is ignored.
REQ-013 A write to TXDATA while the FIFO is full SHALL be dropped and SHALL set the sticky OVF flag.
REQ-014 A write to STATUS with data[3]=1 SHALL clear OVF; all other STATUS bits are read-only.
REQ-015 When enable=1, rw=0 and addr is BASE or BASE+1, the block SHALL drive data combinationally with STATUS; otherwise data SHALL be 32'bz.
REQ-016 STATUS SHALL read as {zero-fill, count[6:0] in bits 10:4, OVF bit3, busy bit2, empty bit1, full bit0}.
REQ-017 busy SHALL be 1 whenever the FSM is not in IDLE.
REQ-018 FIFO SHALL be first-in first-out with wrap-around read and write pointers and an occupancy count of 0..DEPTH.
REQ-019 On a simultaneous push and pop, count SHALL be unchanged.
REQ-019a A push into a full FIFO on the same edge as a pop SHALL be accepted and SHALL NOT set OVF.
REQ-020 FSM states SHALL be IDLE, START, DATA and STOP.
REQ-021 In IDLE with the FIFO non-empty at a rising edge, the FSM SHALL pop the head entry into the shift register and enter START on that edge.
REQ-022 A byte written to an empty FIFO with the FSM in IDLE at edge N SHALL drive txd low from edge N+1 onward.
REQ-023 START SHALL hold txd=0 for CLKDIV cycles, then enter DATA.
REQ-024 DATA SHALL output 8 bits LSB first, each held CLKDIV cycles, using a 3-bit bit index, then enter STOP.
REQ-025 STOP SHALL hold txd=1 for CLKDIV cycles.
REQ-026 At the end of STOP, if the FIFO is non-empty the FSM SHALL pop and enter START on the same edge (back-to-back frames with no idle gap); otherwise it SHALL enter IDLE.
REQ-027 The bit-period counter SHALL be 16 bits wide; it SHALL reload to 0 at each bit boundary and advance at terminal count CLKDIV-1.
REQ-028 txd SHALL be registered (glitch-free) and 1 in IDLE and STOP.
REQ-029 enable SHALL gate bus access only; a frame in progress SHALL complete regardless of enable.

Reset
REQ-030 While reset_n=0, the block SHALL hold: FIFO empty, pointers 0, count 0, OVF=0, FSM=IDLE, bit counter 0, txd=1, data=z.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately, force txd=1 and discard all FIFO contents.
REQ-032 Reset release SHALL be sampled synchronously, with the first state change on the first rising edge after deassertion.

Verification
REQ-033 Reset, then write 0x55 to BASE with CLKDIV=4 -> txd low 4 cycles, then bits 1,0,1,0,1,0,1,0 each for 4 cycles, then high 4 cycles; busy=1 throughout the frame; 40 cycles total.
REQ-034 With CLKDIV=4, write 0xA5 then 0x3C back-to-back -> the 0x3C start bit immediately follows the 0xA5 stop bit; STATUS empty=1 and busy=0 after 80 cycles.
REQ-035 With DEPTH=8, hold the FSM busy and write 10 bytes -> full=1, count=8, OVF=1, and only the first 9 bytes appear on txd (one already popped); then write STATUS with 0x8 -> OVF=0.
REQ-036 Read STATUS with enable=0, or with addr=BASE+2 -> data=z; read with addr=BASE+1 with FIFO holding 3 entries -> data[10:4]=3, empty=0.
REQ-037 Assert reset_n=0 during DATA bit 3 -> txd=1 immediately (asynchronously); after release, STATUS reads 0x2 (empty only) and txd stays high.
